// File: rtl/mat_elem_seq.sv
// mat_elem_seq: block-buffered elementwise sequencer feeding an external pipelined ALU.
// Define MATSEQ_BCAST_EN to let scalar_mode replace the B operand stream with a broadcast scalar.
`ifdef MATSEQ_BCAST_EN
module mat_elem_seq_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  en,
  input  logic                  bcast,
  input  logic [DATA_WIDTH-1:0] scalar,
  input  logic [DATA_WIDTH-1:0] elem,
  output logic [DATA_WIDTH-1:0] opnd
);
  assign opnd = !en ? '0 : (bcast ? scalar : elem);
endmodule
`endif

module mat_elem_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int BURST      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int PIPE_LAT   = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         num_words,
  input  logic [ADDR_WIDTH-1:0]         base_a,
  input  logic [ADDR_WIDTH-1:0]         base_b,
  input  logic [ADDR_WIDTH-1:0]         base_res,
  input  logic                          scalar_mode,
  input  logic [DATA_WIDTH-1:0]         scalar,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          rd_en_a,
  output logic                          rd_en_b,
  output logic [ADDR_WIDTH-1:0]         rd_addr_a,
  output logic [ADDR_WIDTH-1:0]         rd_addr_b,
  input  logic [DATA_WIDTH*LANES-1:0]   rd_data_a,
  input  logic [DATA_WIDTH*LANES-1:0]   rd_data_b,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH*LANES-1:0]   wr_data,
  output logic                          alu_valid_in,
  output logic [DATA_WIDTH*LANES-1:0]   alu_a,
  output logic [DATA_WIDTH*LANES-1:0]   alu_b,
  input  logic                          alu_valid_out,
  input  logic [DATA_WIDTH*LANES-1:0]   alu_result
);
  localparam int W  = DATA_WIDTH * LANES;
  localparam int CW = $clog2(BURST + 1);
  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int WW = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;
  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] nw_q, ba_q, bb_q, br_q, offset, remain, off_nx;
  logic [CW-1:0]         k, blk_n, res_cnt;
  logic [WW-1:0]         wd;
  logic [IW-1:0]         k_idx, cap_idx, res_idx;
  logic                  k_last, res_take, res_bad, rd_b_ok;
  logic [BURST-1:0][W-1:0] buf_a, buf_b, res_buf;

  assign remain  = nw_q - offset;
  assign blk_n   = (remain < ADDR_WIDTH'(BURST)) ? remain[CW-1:0] : CW'(BURST);
  assign off_nx  = offset + ADDR_WIDTH'(blk_n);
  assign k_last  = (k == blk_n - CW'(1));
  assign k_idx   = k[IW-1:0];
  // READ cycle k (k>=1) lands the word requested in cycle k-1
  assign cap_idx = k[IW-1:0] - IW'(1);
  assign res_idx = res_cnt[IW-1:0];

  assign res_take = alu_valid_out && (state == S_ISSUE || state == S_DRAIN) && (res_cnt != blk_n);
  assign res_bad  = alu_valid_out && !res_take;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    busy         = (state != S_IDLE);
    done         = 1'b0;
    rd_en_a      = 1'b0;
    rd_en_b      = 1'b0;
    wr_en        = 1'b0;
    alu_valid_in = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = (num_words == '0) ? S_DONE : S_READ;
      S_READ: begin
        rd_en_a = (k != blk_n);
        rd_en_b = (k != blk_n) && rd_b_ok;
        if (k == blk_n) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        alu_valid_in = 1'b1;
        if (k_last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (res_cnt == blk_n)          state_nx = S_WRITE;
        else if (wd == WW'(PIPE_LAT))  state_nx = S_DONE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (k_last) state_nx = (off_nx < nw_q) ? S_READ : S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign rd_addr_a = rd_en_a ? ba_q + offset + ADDR_WIDTH'(k) : '0;
  assign rd_addr_b = rd_en_b ? bb_q + offset + ADDR_WIDTH'(k) : '0;
  assign wr_addr   = wr_en ? br_q + offset + ADDR_WIDTH'(k) : '0;
  assign wr_data   = wr_en ? res_buf[k_idx] : '0;
  assign alu_a     = alu_valid_in ? buf_a[k_idx] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      nw_q    <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      br_q    <= '0;
      offset  <= '0;
      k       <= '0;
      res_cnt <= '0;
      wd      <= '0;
      error   <= 1'b0;
    end else begin
      if (res_take) res_cnt <= res_cnt + CW'(1);
      case (state)
        S_IDLE: if (start) begin
          nw_q   <= num_words;
          ba_q   <= base_a;
          bb_q   <= base_b;
          br_q   <= base_res;
          offset <= '0;
          k      <= '0;
          error  <= 1'b0;
        end
        S_READ: begin
          if (k == blk_n) begin
            k       <= '0;
            res_cnt <= '0;
          end else begin
            k <= k + CW'(1);
          end
        end
        S_ISSUE: begin
          k  <= k_last ? '0 : k + CW'(1);
          wd <= '0;
        end
        S_DRAIN: begin
          wd <= wd + WW'(1);
          if (res_cnt != blk_n && wd == WW'(PIPE_LAT)) error <= 1'b1;
        end
        S_WRITE: begin
          k <= k_last ? '0 : k + CW'(1);
          if (k_last) offset <= off_nx;
        end
        default: ;
      endcase
      // a stray result outranks the clear from a simultaneous start
      if (res_bad) error <= 1'b1;
    end
  end

  // Operand and result storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge clock) begin
    if (state == S_READ && k != '0) begin
      buf_a[cap_idx] <= rd_data_a;
      buf_b[cap_idx] <= rd_data_b;
    end
    if (res_take) res_buf[res_idx] <= alu_result;
  end

`ifdef MATSEQ_BCAST_EN
  logic                  bcast_q;
  logic [DATA_WIDTH-1:0] scalar_q;
  logic [W-1:0]          b_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      bcast_q  <= 1'b0;
      scalar_q <= '0;
    end else if (state == S_IDLE && start) begin
      bcast_q  <= scalar_mode;
      scalar_q <= scalar;
    end
  end

  assign rd_b_ok = ~bcast_q;
  assign b_word  = buf_b[k_idx];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mat_elem_seq_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .en     (alu_valid_in),
      .bcast  (bcast_q),
      .scalar (scalar_q),
      .elem   (b_word[g*DATA_WIDTH +: DATA_WIDTH]),
      .opnd   (alu_b[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end
`else
  logic unused_bcast;
  assign unused_bcast = ^{scalar_mode, scalar};
  assign rd_b_ok      = 1'b1;
  assign alu_b        = alu_valid_in ? buf_b[k_idx] : '0;
`endif

endmodule

// File: tb/tb_mat_elem_seq.sv
// Bench for mat_elem_seq: memory and lane-add ALU models, directed plus random transactions
// scored against the expected address/data stream of each transaction.
module tb_mat_elem_seq;
  localparam int DW = 32, LN = 4, BU = 4, AW = 16, PL = 7, W = DW * LN;

  logic          clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0] num_words = '0, base_a = '0, base_b = '0, base_res = '0;
  logic          scalar_mode = 1'b0;
  logic [DW-1:0] scalar = '0;
  logic          busy, done, error, rd_en_a, rd_en_b, wr_en, alu_valid_in, alu_valid_out;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [W-1:0]  rd_data_a, rd_data_b, wr_data, alu_a, alu_b, alu_result;

  mat_elem_seq #(.DATA_WIDTH(DW), .LANES(LN), .BURST(BU), .ADDR_WIDTH(AW), .PIPE_LAT(PL)) dut (
    .clock(clock), .reset(reset), .start(start), .num_words(num_words),
    .base_a(base_a), .base_b(base_b), .base_res(base_res),
    .scalar_mode(scalar_mode), .scalar(scalar),
    .busy(busy), .done(done), .error(error),
    .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_valid_in(alu_valid_in), .alu_a(alu_a), .alu_b(alu_b),
    .alu_valid_out(alu_valid_out), .alu_result(alu_result)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < LN; l++) r[l*DW +: DW] = a[l*DW +: DW] + b[l*DW +: DW];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // memories: one-cycle read latency, garbage when not enabled
  logic [W-1:0] mem_a [0:65535];
  logic [W-1:0] mem_b [0:65535];
  always @(posedge clock) begin
    rd_data_a <= rd_en_a ? mem_a[rd_addr_a] : rnd_word();
    rd_data_b <= rd_en_b ? mem_b[rd_addr_b] : rnd_word();
  end

  // ALU: PL-stage lane-wise adder, optionally swallowing one chosen issue
  bit           pv [PL];
  logic [W-1:0] pd [PL];
  int           issue_cnt = 0, drop_at = 0;
  bit           drop_en = 0;
  always @(posedge clock) begin
    pv[0] <= alu_valid_in && !(drop_en && issue_cnt == drop_at);
    pd[0] <= lane_add(alu_a, alu_b);
    if (alu_valid_in) issue_cnt <= issue_cnt + 1;
    for (int i = 1; i < PL; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign alu_valid_out = pv[PL-1];
  assign alu_result    = pd[PL-1];

  // observers, sampled mid-cycle
  logic [AW-1:0] rd_a_log[$], rd_b_log[$], wr_a_log[$];
  logic [W-1:0]  wr_d_log[$];
  int cyc = 0, done_cnt = 0, last_issue = 0, err_cyc = -1;
  always @(negedge clock) begin
    cyc++;
    if (rd_en_a) rd_a_log.push_back(rd_addr_a);
    if (rd_en_b) rd_b_log.push_back(rd_addr_b);
    if (wr_en) begin
      wr_a_log.push_back(wr_addr);
      wr_d_log.push_back(wr_data);
    end
    if (done) done_cnt++;
    if (alu_valid_in) last_issue = cyc;
    if (error && err_cyc < 0) err_cyc = cyc;
  end

  task automatic clear_logs();
    rd_a_log.delete(); rd_b_log.delete(); wr_a_log.delete(); wr_d_log.delete();
    done_cnt = 0;
    issue_cnt = 0;
  endtask

  task automatic fill(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input int n, input bit ramp);
    for (int i = 0; i < n; i++) begin
      mem_a[ba + AW'(i)] = ramp ? {LN{DW'(i)}} : rnd_word();
      mem_b[bb + AW'(i)] = ramp ? {LN{DW'(i)}} : rnd_word();
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ":flags"}, {busy, done, error}, '0);
    chk({tag, ":strobes"}, {rd_en_a, rd_en_b, wr_en, alu_valid_in}, '0);
    chk({tag, ":addrs"}, {rd_addr_a, rd_addr_b, wr_addr}, '0);
    chk({tag, ":wr_data"}, wr_data, '0);
    chk({tag, ":alu_ab"}, alu_a | alu_b, '0);
  endtask

  task automatic run_op(input string tag, input int n, input logic [AW-1:0] ba,
                        input logic [AW-1:0] bb, input logic [AW-1:0] br, input logic sm,
                        input logic [DW-1:0] sc, input bit drop, input bit poke);
    logic [AW-1:0] ea[$], eb[$], ew[$];
    logic [W-1:0]  ed[$];
    logic [AW-1:0] ia, ib;
    bit            bcast;
    bcast = 1'b0;
`ifdef MATSEQ_BCAST_EN
    bcast = sm;
`endif
    for (int i = 0; i < n; i++) begin
      ia = ba + AW'(i);
      ib = bb + AW'(i);
      ea.push_back(ia);
      if (!bcast) eb.push_back(ib);
      if (!drop) begin
        ew.push_back(br + AW'(i));
        ed.push_back(lane_add(mem_a[ia], bcast ? {LN{sc}} : mem_b[ib]));
      end
    end
    clear_logs();
    drop_en = drop;
    drop_at = n - 1;
    @(negedge clock);
    start = 1'b1; num_words = AW'(n); base_a = ba; base_b = bb; base_res = br;
    scalar_mode = sm; scalar = sc;
    @(negedge clock);
    start = 1'b0;
    err_cyc = -1;
    chk({tag, ":busy_after_start"}, busy, 1'b1);
    chk({tag, ":err_cleared"}, error, 1'b0);
    if (poke) begin
      @(negedge clock);
      start = 1'b1; num_words = 1; base_a = ba + 16'd100;
      @(negedge clock);
      start = 1'b0;
    end
    for (int c = 0; c < 2000 && done_cnt == 0; c++) @(negedge clock);
    chk({tag, ":done_within_bound"}, done_cnt > 0, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk({tag, ":done_pulses"}, done_cnt, 1);
    chk({tag, ":error"}, error, drop);
    chk({tag, ":busy_end"}, busy, 1'b0);
    if (drop) chk({tag, ":wd_delay"}, err_cyc - last_issue, PL + 2);
    chk({tag, ":n_rd_a"}, rd_a_log.size(), ea.size());
    chk({tag, ":n_rd_b"}, rd_b_log.size(), eb.size());
    chk({tag, ":n_wr"}, wr_a_log.size(), ew.size());
    for (int i = 0; i < ea.size() && i < rd_a_log.size(); i++)
      chk($sformatf("%s:rd_a[%0d]", tag, i), rd_a_log[i], ea[i]);
    for (int i = 0; i < eb.size() && i < rd_b_log.size(); i++)
      chk($sformatf("%s:rd_b[%0d]", tag, i), rd_b_log[i], eb[i]);
    for (int i = 0; i < ew.size() && i < wr_a_log.size(); i++) begin
      chk($sformatf("%s:wr_addr[%0d]", tag, i), wr_a_log[i], ew[i]);
      chk($sformatf("%s:wr_data[%0d]", tag, i), wr_d_log[i], ed[i]);
    end
    drop_en = 0;
  endtask

  initial begin
    int n;
    logic [AW-1:0] ba, bb, br;
    bit seen_issue;

    repeat (3) @(negedge clock);
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // ramp data, single block: lanes of result k are 2k
    fill(16'h10, 16'h20, 4, 1'b1);
    run_op("blk4", 4, 16'h10, 16'h20, 16'h30, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 4 && k < wr_d_log.size(); k++)
      chk($sformatf("blk4:lanes[%0d]", k), wr_d_log[k], {LN{DW'(2 * k)}});

    // two blocks (4 + 2), with a start pulse mid-run that must be ignored
    fill(16'h10, 16'h20, 6, 1'b0);
    run_op("blk6", 6, 16'h10, 16'h20, 16'h30, 1'b0, '0, 1'b0, 1'b1);

    // zero-length request
    clear_logs();
    @(negedge clock);
    start = 1'b1; num_words = '0;
    @(negedge clock);
    start = 1'b0;
    chk("zero:done_pulse", {busy, done}, 2'b11);
    @(negedge clock);
    chk("zero:back_idle", {busy, done}, 2'b00);
    @(negedge clock);
    chk("zero:no_access", rd_a_log.size() + rd_b_log.size() + wr_a_log.size(), 0);
    chk("zero:one_done", done_cnt, 1);

    // address wrap at top of space
    fill(16'hFFFE, 16'hFFFD, 5, 1'b0);
    run_op("wrap", 5, 16'hFFFE, 16'hFFFD, 16'hFFFF, 1'b0, '0, 1'b0, 1'b0);

    // lost result -> watchdog error, no writes; the following start clears it
    fill(16'h100, 16'h200, 4, 1'b0);
    run_op("drop", 4, 16'h100, 16'h200, 16'h300, 1'b0, '0, 1'b1, 1'b0);
    run_op("after_drop", 3, 16'h100, 16'h200, 16'h310, 1'b0, '0, 1'b0, 1'b0);

    // broadcast request: scalar 5 in place of B when the feature is built in
    fill(16'h40, 16'h50, 4, 1'b1);
    run_op("bcast", 4, 16'h40, 16'h50, 16'h60, 1'b1, 32'd5, 1'b0, 1'b0);

    // reset while draining: outputs drop at once, late results flag an error
    fill(16'h80, 16'h90, 4, 1'b0);
    clear_logs();
    @(negedge clock);
    start = 1'b1; num_words = 4; base_a = 16'h80; base_b = 16'h90; base_res = 16'hA0;
    scalar_mode = 1'b0;
    @(negedge clock);
    start = 1'b0;
    seen_issue = 0;
    for (int c = 0; c < 100; c++) begin
      if (seen_issue && !alu_valid_in) break;
      seen_issue |= alu_valid_in;
      @(negedge clock);
    end
    chk("rst_drain:reached", seen_issue && !alu_valid_in, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_idle_outputs("rst_drain");
    repeat (PL + 2) @(negedge clock);
    chk("rst_drain:stale_err", error, 1'b1);
    chk("rst_drain:no_writes", wr_a_log.size(), 0);
    run_op("post_rst", 4, 16'h80, 16'h90, 16'hA0, 1'b0, '0, 1'b0, 1'b0);

    // random transactions, including spans that cross the top of the address space
    for (int t = 0; t < 8; t++) begin
      n  = $urandom_range(1, 11);
      ba = AW'($urandom);
      bb = AW'($urandom);
      br = AW'($urandom);
      if ($urandom_range(0, 2) == 0) ba = 16'hFFFF - AW'($urandom_range(0, 3));
      fill(ba, bb, n, 1'b0);
      run_op($sformatf("rnd%0d", t), n, ba, bb, br, 1'($urandom_range(0, 1)), $urandom,
             1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mat_elem_seq.md
MAT_ELEM_SEQ -- requirements
Module: mat_elem_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, bits per element.
REQ-002 SHALL have parameter LANES, 4, elements per memory word; ALU word width W = DATA_WIDTH*LANES.
REQ-003 SHALL have parameter BURST, 4, words per block buffer (>=1).
REQ-004 SHALL have parameter ADDR_WIDTH, 16, word-address and word-count width.
REQ-005 SHALL have parameter PIPE_LAT, 7, external ALU latency in cycles (>=1).
REQ-006 SHALL have ports, in order: clock in 1 sole clock; reset in 1 synchronous active-high reset.
REQ-007 SHALL have: start in 1; num_words in ADDR_WIDTH; base_a, base_b, base_res in ADDR_WIDTH each; scalar_mode in 1; scalar in DATA_WIDTH.
REQ-008 SHALL have: busy out 1; done out 1 one-cycle completion pulse; error out 1 sticky fault flag.
REQ-009 SHALL have: rd_en_a, rd_en_b out 1; rd_addr_a, rd_addr_b out ADDR_WIDTH; rd_data_a, rd_data_b in W, valid the cycle after rd_en.
REQ-010 SHALL have: wr_en out 1; wr_addr out ADDR_WIDTH; wr_data out W.
REQ-011 SHALL have: alu_valid_in out 1; alu_a, alu_b out W; alu_valid_out in 1; alu_result in W.

Function
REQ-012 SHALL implement states IDLE, READ, ISSUE, DRAIN, WRITE, DONE; busy=1 in every state except IDLE.
REQ-013 IDLE: start=1 latches num_words, bases, scalar_mode, scalar, clears error, block offset=0; -> DONE if num_words==0 (no memory access), else READ. start outside IDLE ignored.
REQ-014 Block size n = min(BURST, num_words - offset).
REQ-015 READ lasts n+1 cycles: cycle k<n drives rd_en_a=1, rd_addr_a=base_a+offset+k (rd_en_b/rd_addr_b likewise from base_b); word k captured into buffer k at end of cycle k+1; -> ISSUE.
REQ-016 ISSUE lasts n cycles: cycle k drives alu_valid_in=1, alu_a=bufA[k], alu_b=bufB[k]; -> DRAIN.
REQ-017 Results SHALL be captured in arrival order into result buffer whenever alu_valid_out=1 in ISSUE or DRAIN; result count increments per capture.
REQ-018 DRAIN: -> WRITE when result count == n; watchdog: if count < n PIPE_LAT+1 cycles after last issue, set error, -> DONE without writing.
REQ-019 alu_valid_out=1 with count already == n, or in IDLE/READ/WRITE/DONE, SHALL set error and be ignored.
REQ-020 WRITE lasts n cycles: cycle k drives wr_en=1, wr_addr=base_res+offset+k, wr_data=result[k]; then offset+=n; -> READ if offset<num_words, else DONE.
REQ-021 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-022 DONE: done=1 for exactly one cycle; -> IDLE; error holds until next accepted start.
REQ-023 All strobes (rd_en_*, wr_en, alu_valid_in) SHALL be 0 outside their stated cycles; data/address outputs are don't-care when their strobe is 0.

Reset
REQ-024 reset sampled high at a clock edge SHALL force IDLE, offset=0, counts=0, error=0, and all outputs 0 the following cycle, including mid-operation; in-flight ALU results after reset SHALL set error per REQ-019.
REQ-025 Buffer contents need not be cleared by reset.

Configuration
REQ-026 Macro MATSEQ_BCAST_EN defined: latched scalar_mode=1 suppresses all B reads (rd_en_b=0) and drives alu_b with latched scalar replicated across all LANES.
REQ-027 MATSEQ_BCAST_EN undefined: scalar_mode and scalar ignored; B always read; no broadcast logic synthesised.

Verification (LANES=4, BURST=4, PIPE_LAT=7, ALU model = lane-wise A+B)
REQ-028 num_words=4, base_a=0x10, base_b=0x20, base_res=0x30, A[k]=B[k]=k replicated -> wr_addr 0x30..0x33 carry lanes 0,2,4,6; one done pulse; error=0.
REQ-029 num_words=6 -> two blocks (n=4 then n=2); READ reads 0x10..0x13 then 0x14..0x15; writes 0x30..0x35 in order; single done.
REQ-030 num_words=0 -> done exactly two cycles after start edge (IDLE->DONE->IDLE), no rd_en/wr_en ever asserted.
REQ-031 ALU model drops last result of block -> error=1 at watchdog expiry, no wr_en, done pulse follows; next start clears error.
REQ-032 With MATSEQ_BCAST_EN, scalar_mode=1, scalar=5, A[k]=k -> rd_en_b never high, results lanes k+5; without macro same stimulus reads B.
REQ-033 reset asserted during DRAIN -> next cycle busy=0, all strobes 0; stale alu_valid_out sets error, start afterwards runs cleanly.
